// File: rtl/ebpf_pkg.sv
// Constants and types shared by the eBPF core, its instruction/data memory and
// the memory arbiter.
package ebpf_pkg;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 12;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_FETCH,
        GNT_LS
    } grant_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core-side request/response ports and memory-side bus of the memory arbiter.
// The master modport is the core plus memory; the slave modport is the arbiter.
interface mem_arbiter_if
    import ebpf_pkg::*;
#(
    parameter int DATA_W = ebpf_pkg::DATA_W,
    parameter int ADDR_W = ebpf_pkg::ADDR_W
) ();

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ack;
    logic [DATA_W-1:0] fetch_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_ack;
    logic [DATA_W-1:0] ls_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              mem_write_enable;

    modport master (
        output fetch_req, fetch_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_data_out,
        input  fetch_ack, fetch_rdata, ls_ack, ls_rdata,
        input  mem_address, mem_data_in, mem_write_enable
    );

    modport slave (
        input  fetch_req, fetch_addr, ls_req, ls_we, ls_addr, ls_wdata, mem_data_out,
        output fetch_ack, fetch_rdata, ls_ack, ls_rdata,
        output mem_address, mem_data_in, mem_write_enable
    );

endinterface

// File: rtl/mem_arbiter.sv
// Shares the single-port instruction/data memory between fetch and load/store.
// Load/store has priority; a streak counter guarantees fetch progress.
module mem_arbiter
    import ebpf_pkg::*;
#(
    parameter int DATA_W     = ebpf_pkg::DATA_W,
    parameter int ADDR_W     = ebpf_pkg::ADDR_W,
    parameter int MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    localparam int SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    grant_t            grant;
    logic [SW-1:0]     streak;
    logic [ADDR_W-1:0] addr_mux;
    logic              fetch_ack_q;
    logic              ls_ack_q;
    logic [DATA_W-1:0] fetch_rdata_q;
    logic [DATA_W-1:0] ls_rdata_q;

    // Fetch overrides load/store only once the starvation streak is exhausted.
    always_comb begin
        grant = GNT_NONE;
        if (!rst) begin
            if (bus.ls_req && !(bus.fetch_req && streak == STREAK_MAX))
                grant = GNT_LS;
            else if (bus.fetch_req)
                grant = GNT_FETCH;
        end
    end

    always_comb begin
        addr_mux = bus.ls_addr;
        if (grant == GNT_FETCH)
            addr_mux = bus.fetch_addr;
    end

    assign bus.mem_address      = addr_mux;
    assign bus.mem_data_in      = bus.ls_wdata;
    assign bus.mem_write_enable = (grant == GNT_LS) && bus.ls_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_ack_q   <= 1'b0;
            ls_ack_q      <= 1'b0;
            fetch_rdata_q <= '0;
            ls_rdata_q    <= '0;
            streak        <= '0;
        end else begin
            fetch_ack_q <= (grant == GNT_FETCH);
            ls_ack_q    <= (grant == GNT_LS);

            if (grant == GNT_FETCH)
                fetch_rdata_q <= bus.mem_data_out;
            if (grant == GNT_LS && !bus.ls_we)
                ls_rdata_q <= bus.mem_data_out;

            // Counts only LS wins that left a waiting fetch behind.
            if (grant == GNT_LS && bus.fetch_req) begin
                if (streak != STREAK_MAX)
                    streak <= streak + 1'b1;
            end else begin
                streak <= '0;
            end
        end
    end

    assign bus.fetch_ack   = fetch_ack_q;
    assign bus.ls_ack      = ls_ack_q;
    assign bus.fetch_rdata = fetch_rdata_q;
    assign bus.ls_rdata    = ls_rdata_q;

endmodule
